fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a first-word-fall-through FIFO.
// Define FETCH_PERF_EN to add the perf_stall_cnt output (decode-starved cycle counter).
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr, wptr_nxt, rptr, rptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [31:0]     pc, pc_nxt;
  logic            pending, pending_nxt;
  logic            discard, discard_nxt;
  logic            req_nxt;
  logic            grant, resp, push, pop;
  entry_t          push_entry;

  assign imem_addr = pc;
  assign out_valid = (count != '0);
  assign out_inst  = mem[rptr].inst;
  assign out_pc    = mem[rptr].pc;

  // Next-state: handshakes, FIFO bookkeeping, then redirect and reset overrides.
  always_comb begin
    grant       = imem_req & imem_gnt;
    resp        = imem_rvalid & pending;
    push        = resp & ~discard & ~redirect;
    pop         = out_valid & out_ready & ~redirect;
    pc_nxt      = pc;
    wptr_nxt    = wptr;
    rptr_nxt    = rptr;
    count_nxt   = count + CW'(push) - CW'(pop);
    pending_nxt = grant | (pending & ~resp);
    discard_nxt = discard & ~resp;
    // pc has already advanced past the outstanding request, so its address is pc - 4
    push_entry  = '{inst: imem_rdata, pc: pc - 32'd4};

    if (grant) pc_nxt = pc + 32'd4;
    if (push)  wptr_nxt = wptr + AW'(1);
    if (pop)   rptr_nxt = rptr + AW'(1);

    if (redirect) begin
      pc_nxt      = redirect_pc & ~32'h3;
      discard_nxt = pending_nxt;
      wptr_nxt    = '0;
      rptr_nxt    = '0;
      count_nxt   = '0;
    end

    if (rst) begin
      pc_nxt      = RESET_PC & ~32'h3;
      discard_nxt = pending_nxt;
      wptr_nxt    = '0;
      rptr_nxt    = '0;
      count_nxt   = '0;
    end

    // A grant reserves a FIFO slot, so the full check only needs the committed count
    req_nxt = ~rst & ~pending_nxt & ~discard_nxt & (count_nxt < CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    pc       <= pc_nxt;
    wptr     <= wptr_nxt;
    rptr     <= rptr_nxt;
    count    <= count_nxt;
    pending  <= pending_nxt;
    discard  <= discard_nxt;
    imem_req <= req_nxt;
    if (push) mem[wptr] <= push_entry;
  end

`ifdef FETCH_PERF_EN
  // Saturating count of cycles where decode is ready but starved
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (out_ready && !out_valid && !(&perf_stall_cnt)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
